// File: rtl/oai21_selftest_ctrl.sv
// BIST sequencer: sweeps all 8 oai21 input vectors, samples ZN, counts mismatches.
// Optional first-fail capture when GF180MCU_OAI21_SELFTEST_FAILCAP_EN is defined.
module oai21_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN_IN,
  output logic             DRV_A1,
  output logic             DRV_A2,
  output logic             DRV_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       VEC_IDX
`ifdef GF180MCU_OAI21_SELFTEST_FAILCAP_EN
  ,
  output logic             FAIL_VLD,
  output logic [2:0]       FAIL_VEC
`endif
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (PASSES < 1) begin : g_bad_passes
    $error("PASSES must be >= 1");
  end

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PC_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  // ZN expected for vector index {B,A2,A1} = 0..7
  localparam logic [7:0] GOLD = 8'b0001_1111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pc, pc_n;
  logic [2:0] vec, vec_n;
  logic busy, busy_n;
  logic done, done_n;
  logic pass, pass_n;
  logic [ERR_W-1:0] err, err_n, err_upd;
  logic mis;
  logic fvld, fvld_n;
  logic [2:0] fvec, fvec_n;

  assign mis = (ZN_IN != GOLD[vec]);
  assign err_upd = (mis && err != ERR_MAX) ? err + 1'b1 : err;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    vec_n   = vec;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    err_n   = err;
    fvld_n  = fvld;
    fvec_n  = fvec;
    unique case (state)
      IDLE: begin
        if (START && !ABORT) begin
          err_n   = '0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
          vec_n   = 3'd0;
          cnt_n   = SET_LD;
          pc_n    = '0;
          fvld_n  = 1'b0;
          fvec_n  = 3'd0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (ABORT) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          vec_n   = 3'd0;
          pass_n  = 1'b0;
        end else if (cnt == '0) begin
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SAMPLE: begin
        if (ABORT) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          vec_n   = 3'd0;
          pass_n  = 1'b0;
        end else begin
          err_n = err_upd;
          if (mis && !fvld) begin
            fvld_n = 1'b1;
            fvec_n = vec;
          end
          if (vec != 3'd7) begin
            vec_n   = vec + 3'd1;
            cnt_n   = SET_LD;
            state_n = SETTLE;
          end else if (pc != PC_LAST) begin
            vec_n   = 3'd0;
            pc_n    = pc + 1'b1;
            cnt_n   = SET_LD;
            state_n = SETTLE;
          end else begin
            state_n = FINISH;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            vec_n   = 3'd0;
            pass_n  = (err_upd == '0);
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      pc    <= '0;
      vec   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      err   <= '0;
      fvld  <= 1'b0;
      fvec  <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pc    <= pc_n;
      vec   <= vec_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
      err   <= err_n;
      fvld  <= fvld_n;
      fvec  <= fvec_n;
    end
  end

  assign DRV_A1  = vec[0];
  assign DRV_A2  = vec[1];
  assign DRV_B   = vec[2];
  assign BUSY    = busy;
  assign DONE    = done;
  assign PASS    = pass;
  assign ERR_CNT = err;
  assign VEC_IDX = vec;

`ifdef GF180MCU_OAI21_SELFTEST_FAILCAP_EN
  assign FAIL_VLD = fvld;
  assign FAIL_VEC = fvec;
`else
  logic unused_fcap;
  assign unused_fcap = ^{fvld, fvec};
`endif

endmodule

// File: tb/tb_oai21_selftest_ctrl.sv
// Directed bench for oai21_selftest_ctrl: table of full runs plus
// hand-written re-start, abort and mid-run reset sequences.
module tb_oai21_selftest_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  int   zmode = 0;

  always #5 CLK = ~CLK;

  function automatic logic zn_of(int m, logic a1, logic a2, logic b);
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return ~((a1 | a2) & b);
  endfunction

  logic [2:0] a1, a2, b, zn, busy_w, done_w, pass_w;
  logic [2:0] vec0, vec1, vec2;
  logic [7:0] err0, err1;
  logic [2:0] err2;
  logic [7:0] errv [3];
  logic [2:0] fv0, fv1, fv2;
  logic [2:0] fl;

  assign errv[0] = err0;
  assign errv[1] = err1;
  assign errv[2] = {5'b0, err2};

  for (genvar g = 0; g < 3; g++) begin : g_zn
    assign zn[g] = zn_of(zmode, a1[g], a2[g], b[g]);
  end

`ifdef GF180MCU_OAI21_SELFTEST_FAILCAP_EN
  `define FCAP(V, F) , .FAIL_VLD(V), .FAIL_VEC(F)
`else
  `define FCAP(V, F)
  assign fl = 3'b0;
  assign fv0 = 3'b0;
  assign fv1 = 3'b0;
  assign fv2 = 3'b0;
`endif

  oai21_selftest_ctrl u0 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN_IN(zn[0]),
    .DRV_A1(a1[0]), .DRV_A2(a2[0]), .DRV_B(b[0]), .BUSY(busy_w[0]),
    .DONE(done_w[0]), .PASS(pass_w[0]), .ERR_CNT(err0), .VEC_IDX(vec0)
    `FCAP(fl[0], fv0)
  );

  oai21_selftest_ctrl #(.PASSES(2)) u1 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN_IN(zn[1]),
    .DRV_A1(a1[1]), .DRV_A2(a2[1]), .DRV_B(b[1]), .BUSY(busy_w[1]),
    .DONE(done_w[1]), .PASS(pass_w[1]), .ERR_CNT(err1), .VEC_IDX(vec1)
    `FCAP(fl[1], fv1)
  );

  oai21_selftest_ctrl #(.PASSES(2), .ERR_W(3)) u2 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN_IN(zn[2]),
    .DRV_A1(a1[2]), .DRV_A2(a2[2]), .DRV_B(b[2]), .BUSY(busy_w[2]),
    .DONE(done_w[2]), .PASS(pass_w[2]), .ERR_CNT(err2), .VEC_IDX(vec2)
    `FCAP(fl[2], fv2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic kick();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic quiet(input int n, output int nd);
    nd = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      nd += int'(done_w[0]) + int'(done_w[1]) + int'(done_w[2]);
    end
  endtask

  task automatic run_row(input int inst, input int mode, input int xerr,
                         input int xpass, input int xlat, input bit seq);
    int lat, nd;
    bit seq_ok, idle;
    lat = -1;
    nd = 0;
    seq_ok = 1'b1;
    zmode = mode;
    kick();
    for (int k = 1; k <= 120; k++) begin
      @(negedge CLK);
      if (seq && k <= 25) begin
        int ev;
        ev = (k <= 24) ? (k - 1) / 3 : 0;
        if (busy_w[0] != (k <= 24)) seq_ok = 1'b0;
        if (int'(vec0) != ev) seq_ok = 1'b0;
        if (int'({b[0], a2[0], a1[0]}) != ev) seq_ok = 1'b0;
      end
      if (done_w[inst]) begin
        nd++;
        if (lat < 0) lat = k;
      end
      idle = (busy_w == 3'b000);
      if (idle && lat >= 0 && k > xlat) break;
    end
    chk($sformatf("lat[%0d,m%0d]", inst, mode), lat, xlat);
    chk($sformatf("ndone[%0d,m%0d]", inst, mode), nd, 1);
    chk($sformatf("err[%0d,m%0d]", inst, mode), int'(errv[inst]), xerr);
    chk($sformatf("pass[%0d,m%0d]", inst, mode), int'(pass_w[inst]), xpass);
    if (seq) chk("drive_seq", int'(seq_ok), 1);
  endtask

  typedef struct {
    int inst;
    int mode;
    int xerr;
    int xpass;
    int xlat;
    bit seq;
  } row_t;

  row_t tbl[6];

  initial begin
    int nd;
    tbl[0] = '{0, 0, 0, 1, 25, 1'b1};
    tbl[1] = '{0, 1, 3, 0, 25, 1'b0};
    tbl[2] = '{0, 2, 5, 0, 25, 1'b0};
    tbl[3] = '{1, 2, 10, 0, 49, 1'b0};
    tbl[4] = '{2, 2, 7, 0, 49, 1'b0};
    tbl[5] = '{1, 0, 0, 1, 49, 1'b0};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outs", int'({busy_w, done_w, pass_w, a1, a2, b}), 0);
    chk("rst_err_vec", int'({err0, vec0}), 0);
    RST = 1'b0;

    @(negedge CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    ABORT = 1'b0;
    @(negedge CLK);
    chk("start_abort_idle", int'(busy_w), 0);

    for (int i = 0; i < 6; i++) begin
      run_row(tbl[i].inst, tbl[i].mode, tbl[i].xerr, tbl[i].xpass,
              tbl[i].xlat, tbl[i].seq);
`ifdef GF180MCU_OAI21_SELFTEST_FAILCAP_EN
      if (i == 1) begin
        chk("fail_vld", int'(fl[0]), 1);
        chk("fail_vec", int'(fv0), 5);
      end
`endif
    end

    zmode = 0;
    kick();
    begin
      int lat, cnt;
      lat = -1;
      cnt = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge CLK);
        if (k == 5) START = 1'b1;
        if (k == 6) START = 1'b0;
        if (done_w[0]) begin
          cnt++;
          if (lat < 0) lat = k;
        end
      end
      chk("restart_lat", lat, 25);
      chk("restart_ndone", cnt, 1);
      chk("restart_pass", int'(pass_w[0]), 1);
      chk("restart_err", int'(err0), 0);
    end
    quiet(40, nd);

    zmode = 0;
    kick();
    repeat (10) @(negedge CLK);
    ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    @(negedge CLK);
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_drv", int'({b[0], a2[0], a1[0], vec0}), 0);
    quiet(30, nd);
    chk("abort_nodone", nd, 0);
    run_row(0, 0, 0, 1, 25, 1'b0);

    zmode = 2;
    kick();
    repeat (12) @(negedge CLK);
    chk("pre_rst_err", int'(err0), 3);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("midrst_outs", int'({busy_w[0], done_w[0], pass_w[0], a1[0], a2[0], b[0]}), 0);
    chk("midrst_err_vec", int'({err0, vec0}), 0);
    quiet(30, nd);
    chk("midrst_nodone", nd, 0);
    run_row(0, 0, 0, 1, 25, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oai21_selftest_ctrl.md
Name: oai21_selftest_ctrl

Overview:
Built-in self-test sequencer for one oai21 cell instance (ZN = !((A1|A2)&B)).
- Applies all 8 input vectors to the cell under test.
- Waits a programmable settle time after each vector, then samples the cell's ZN.
- Compares each sample against the golden function and counts mismatches.
- Sits beside the cell in the characterisation/test wrapper. Kicked off by a START/DONE handshake from the test host.

Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before ZN is sampled. Legal range ≥1; elaboration error if 0.
- PASSES, default 1: number of complete 8-vector sweeps per run. Legal range ≥1.
- ERR_W, default 8: width of the mismatch counter.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE.
- ABORT  input  1  cancels a run in progress.
- ZN_IN  input  1  ZN of the cell under test.
- DRV_A1  output  1  drive to cell A1.
- DRV_A2  output  1  drive to cell A2.
- DRV_B  output  1  drive to cell B.
- BUSY  output  1  high while a run is active.
- DONE  output  1  one-cycle pulse at run completion.
- PASS  output  1  run result; valid from DONE until next START.
- ERR_CNT  output  ERR_W  saturating mismatch count for the current/last run.
- VEC_IDX  output  3  index of the vector currently applied.

Behaviour:
- Reset: RST is synchronous, active-high, on CLK.
  - All outputs go to 0: DRV_*, BUSY, DONE, PASS, ERR_CNT, VEC_IDX.
  - State goes to IDLE. Pass and settle counters clear.
  - RST mid-run discards the run; no DONE is produced.
- Vector map: DRV_A1 = VEC_IDX[0], DRV_A2 = VEC_IDX[1], DRV_B = VEC_IDX[2].
- Golden ZN by index 0..7: 1,1,1,1,1,0,0,0.
- All drive outputs are registered. Only state SETTLE holds a counter.
- IDLE:
  - On START=1 (and ABORT=0): clear ERR_CNT and PASS, set BUSY=1, VEC_IDX=0, settle count = SETTLE_CYCLES-1, pass count = 0 → SETTLE.
- SETTLE:
  - Drives are stable. Decrement the settle count.
  - When the count reaches 0 → SAMPLE.
- SAMPLE (one cycle):
  - If ZN_IN != golden[VEC_IDX], increment ERR_CNT, saturating at 2^ERR_W-1.
  - If VEC_IDX < 7: increment VEC_IDX, reload settle count → SETTLE.
  - If VEC_IDX = 7 and pass count < PASSES-1: wrap VEC_IDX to 0, increment pass count, reload → SETTLE.
  - Otherwise → FINISH.
- FINISH (one cycle):
  - DONE=1, BUSY=0, DRV_* = 0, VEC_IDX = 0.
  - PASS = (ERR_CNT == 0 after the final compare) → IDLE.
- Timing: START accepted at edge t → vector 0 visible after t.
  - Vector k is sampled SETTLE_CYCLES cycles after it is applied.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE pulses in the cycle after the last SAMPLE, i.e. PASSES×8×(SETTLE_CYCLES+1) cycles after acceptance. Defaults: DONE at cycle t+25.
- START while BUSY: ignored, no queuing.
- START and ABORT both high in IDLE: ABORT wins and START is dropped.
- ABORT in SETTLE or SAMPLE:
  - Next state IDLE. BUSY=0, DRV_*=0, VEC_IDX=0, PASS=0.
  - ERR_CNT holds its partial count. No DONE.
  - A compare in the same SAMPLE cycle as ABORT is discarded.
- ABORT in FINISH: ignored; the run completes normally.
- RST has priority over ABORT, which has priority over START.

Optional Feature:
Macro: GF180MCU_OAI21_SELFTEST_FAILCAP_EN.
- When defined, two extra outputs are added:
  - FAIL_VLD (1 bit): set on the first mismatch of a run.
  - FAIL_VEC (3 bits): VEC_IDX of that first mismatch.
- Both clear on START acceptance and on RST, and hold until the next START.
- Later mismatches do not overwrite them.
- When the macro is undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Defaults, ZN_IN driven by a correct oai21 model, START at t → DONE pulse at t+25, PASS=1, ERR_CNT=0. BUSY high for exactly cycles t+1..t+24. Drive sequence steps 0..7.
2. ZN_IN stuck at 1 → mismatches at indices 5,6,7: ERR_CNT=3, PASS=0. With FAILCAP_EN: FAIL_VLD=1, FAIL_VEC=5.
3. ZN_IN stuck at 0, PASSES=2 → ERR_CNT=10 (5 per pass), DONE at t+49. With ERR_W=3 → ERR_CNT=7 (saturated), PASS=0.
4. START re-pulsed at t+5 during a run → ignored; single DONE at t+25, results as in scenario 1.
5. ABORT at t+10 → BUSY=0 and DRV_*=0 the next cycle, no DONE in the following 30 cycles. A new START then yields a normal run.
6. RST asserted for one cycle at t+12 mid-run → all outputs 0 on the next edge, no DONE. START after reset → full 25-cycle run, PASS=1.
